// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch channel between the fetch sequencer and the memory.
//   IMem_Req   : fetch request, held until IMem_Valid
//   IMem_Addr  : fetch address, stable while IMem_Req is high
//   IMem_Valid : response strobe for the current request
//   IMem_Data  : instruction, valid with IMem_Valid
// master = fetch sequencer, slave = instruction memory.
interface pc_fetch_sequencer_if #(
   parameter int unsigned PC_WIDTH    = 13,
   parameter int unsigned INSTR_WIDTH = 16
);
   logic                   IMem_Req;
   logic [PC_WIDTH-1:0]    IMem_Addr;
   logic                   IMem_Valid;
   logic [INSTR_WIDTH-1:0] IMem_Data;

   modport master (output IMem_Req, IMem_Addr, input  IMem_Valid, IMem_Data);
   modport slave  (input  IMem_Req, IMem_Addr, output IMem_Valid, IMem_Data);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-side sequencer: owns the PC register, issues instruction-memory
// requests, parks a response in a skid register during stalls, discards
// in-flight responses after a redirect, and maintains the IF/ID latch plus
// the per-stage valid bits used as write-enables / bubble markers.
// Ports:
//   CLK, Reset_n          : clock, synchronous active-low reset
//   Stall                 : hazard stall (hold PC and IF/ID, bubble into EX)
//   Redirect, Next_PC     : taken jump/branch and its target
//   REG/EX/MEM_Mask       : kill the instruction entering ID / EX / MEM
//   imem                  : instruction-memory request/response channel
//   Old_PC                : current PC register
//   IF_Instr, IF_PC       : IF/ID latch contents
//   IF/ID/EX/MEM_Valid    : stage valid bits
module pc_fetch_sequencer #(
   parameter int unsigned         PC_WIDTH    = 13,
   parameter int unsigned         INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   CLK,
   input  logic                   Reset_n,
   input  logic                   Stall,
   input  logic                   Redirect,
   input  logic [PC_WIDTH-1:0]    Next_PC,
   input  logic                   REG_Mask,
   input  logic                   EX_Mask,
   input  logic                   MEM_Mask,
   pc_fetch_sequencer_if.master   imem,
   output logic [PC_WIDTH-1:0]    Old_PC,
   output logic [INSTR_WIDTH-1:0] IF_Instr,
   output logic [PC_WIDTH-1:0]    IF_PC,
   output logic                   IF_Valid,
   output logic                   ID_Valid,
   output logic                   EX_Valid,
   output logic                   MEM_Valid
);

   typedef enum logic [1:0] {IDLE, REQ, HELD, DROP} state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    addr;
   logic                   req;
   logic [INSTR_WIDTH-1:0] skid;

   assign imem.IMem_Req  = req;
   assign imem.IMem_Addr = addr;
   assign Old_PC         = pc;

   // Fetch FSM, IF/ID latch and stage valid pipeline.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         addr      <= RESET_PC;
         req       <= 1'b0;
         skid      <= '0;
         IF_Instr  <= '0;
         IF_PC     <= '0;
         IF_Valid  <= 1'b0;
         ID_Valid  <= 1'b0;
         EX_Valid  <= 1'b0;
         MEM_Valid <= 1'b0;
      end else begin
         // A redirect overrides a stall, so the pipeline advances to flush.
         if (Stall && !Redirect) begin
            EX_Valid  <= 1'b0;
            MEM_Valid <= EX_Valid & ~MEM_Mask;
         end else begin
            ID_Valid  <= IF_Valid & ~REG_Mask;
            EX_Valid  <= ID_Valid & ~EX_Mask;
            MEM_Valid <= EX_Valid & ~MEM_Mask;
         end

         case (state)
            IDLE: begin
               state <= REQ;
               req   <= 1'b1;
               if (Redirect) begin
                  pc       <= Next_PC;
                  addr     <= Next_PC;
                  IF_Valid <= 1'b0;
               end
            end

            REQ: begin
               if (Redirect) begin
                  pc       <= Next_PC;
                  IF_Valid <= 1'b0;
                  // Nothing outstanding once this response lands: retarget now.
                  if (imem.IMem_Valid) addr  <= Next_PC;
                  else                 state <= DROP;
               end else if (imem.IMem_Valid && !Stall) begin
                  IF_Instr <= imem.IMem_Data;
                  IF_PC    <= addr;
                  IF_Valid <= 1'b1;
                  pc       <= pc + PC_WIDTH'(1);
                  addr     <= pc + PC_WIDTH'(1);
               end else if (imem.IMem_Valid) begin
                  skid  <= imem.IMem_Data;
                  state <= HELD;
                  req   <= 1'b0;
               end else if (!Stall) begin
                  IF_Valid <= 1'b0;
               end
            end

            HELD: begin
               if (Redirect) begin
                  pc       <= Next_PC;
                  addr     <= Next_PC;
                  IF_Valid <= 1'b0;
                  skid     <= '0;
                  state    <= REQ;
                  req      <= 1'b1;
               end else if (!Stall) begin
                  IF_Instr <= skid;
                  IF_PC    <= addr;
                  IF_Valid <= 1'b1;
                  pc       <= pc + PC_WIDTH'(1);
                  addr     <= pc + PC_WIDTH'(1);
                  state    <= REQ;
                  req      <= 1'b1;
               end
            end

            DROP: begin
               IF_Valid <= 1'b0;
               if (Redirect) pc <= Next_PC;
               // The discarded response frees the bus; fetch the newest target.
               if (imem.IMem_Valid) begin
                  addr  <= Redirect ? Next_PC : pc;
                  state <= REQ;
               end
            end

            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// flag-based behavioural model of the fetch rules.
module tb_pc_fetch_sequencer;
   localparam int unsigned PW = 13;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst_n, stall, redirect, reg_mask, ex_mask, mem_mask;
   logic [PW-1:0] next_pc, old_pc, if_pc;
   logic [IW-1:0] if_instr;
   logic          if_valid, id_valid, ex_valid, mem_valid;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int lat = 0;
   int mem_cnt = 0;

   pc_fetch_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

   pc_fetch_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(13'd0)) dut (
      .CLK(clk), .Reset_n(rst_n), .Stall(stall), .Redirect(redirect),
      .Next_PC(next_pc), .REG_Mask(reg_mask), .EX_Mask(ex_mask),
      .MEM_Mask(mem_mask), .imem(bus), .Old_PC(old_pc), .IF_Instr(if_instr),
      .IF_PC(if_pc), .IF_Valid(if_valid), .ID_Valid(id_valid),
      .EX_Valid(ex_valid), .MEM_Valid(mem_valid)
   );

   always #5 clk = ~clk;

   // Behavioural model: started / parked / discard flags describe the fetch side.
   bit            m_started, m_parked, m_discard;
   logic [PW-1:0] m_pc, m_addr, m_if_pc;
   logic [IW-1:0] m_if_instr, m_park;
   bit            m_ifv, m_idv, m_exv, m_memv;

   task automatic model_step();
      bit hold, n_if, n_id, n_ex, n_mem;
      if (!rst_n) begin
         m_started = 0; m_parked = 0; m_discard = 0;
         m_pc = '0; m_addr = '0; m_if_pc = '0; m_if_instr = '0; m_park = '0;
         m_ifv = 0; m_idv = 0; m_exv = 0; m_memv = 0;
         return;
      end
      hold  = stall && !redirect;
      n_id  = hold ? m_idv : (m_ifv && !reg_mask);
      n_ex  = hold ? 1'b0  : (m_idv && !ex_mask);
      n_mem = m_exv && !mem_mask;
      n_if  = m_ifv;
      if (!m_started) begin
         m_started = 1;
         if (redirect) begin m_pc = next_pc; m_addr = next_pc; n_if = 0; end
      end else if (m_parked) begin
         if (redirect) begin
            m_pc = next_pc; m_addr = next_pc; n_if = 0; m_parked = 0;
         end else if (!stall) begin
            m_if_instr = m_park; m_if_pc = m_pc; n_if = 1;
            m_pc = m_pc + PW'(1); m_addr = m_pc; m_parked = 0;
         end
      end else if (m_discard) begin
         n_if = 0;
         if (redirect) m_pc = next_pc;
         if (bus.IMem_Valid) begin m_discard = 0; m_addr = m_pc; end
      end else begin
         if (redirect) begin
            m_pc = next_pc; n_if = 0;
            if (bus.IMem_Valid) m_addr = next_pc;
            else                m_discard = 1;
         end else if (bus.IMem_Valid && !stall) begin
            m_if_instr = bus.IMem_Data; m_if_pc = m_addr; n_if = 1;
            m_pc = m_pc + PW'(1); m_addr = m_pc;
         end else if (bus.IMem_Valid) begin
            m_park = bus.IMem_Data; m_parked = 1;
         end else if (!stall) begin
            n_if = 0;
         end
      end
      m_ifv = n_if; m_idv = n_id; m_exv = n_ex; m_memv = n_mem;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_req",    32'(bus.IMem_Req),  32'(m_started && !m_parked));
         cmp("m_addr",   32'(bus.IMem_Addr), 32'(m_addr));
         cmp("m_old_pc", 32'(old_pc),        32'(m_pc));
         cmp("m_if_ins", 32'(if_instr),      32'(m_if_instr));
         cmp("m_if_pc",  32'(if_pc),         32'(m_if_pc));
         cmp("m_if_v",   32'(if_valid),      32'(m_ifv));
         cmp("m_id_v",   32'(id_valid),      32'(m_idv));
         cmp("m_ex_v",   32'(ex_valid),      32'(m_exv));
         cmp("m_mem_v",  32'(mem_valid),     32'(m_memv));
      end
   end

   // Memory: responds after `lat` wait cycles with data = addr + 16'h100.
   task automatic drive(input bit st, input bit rd, input logic [PW-1:0] np,
                        input bit rm, input bit em, input bit mm, input bit spur);
      stall = st; redirect = rd; next_pc = np;
      reg_mask = rm; ex_mask = em; mem_mask = mm;
      if (bus.IMem_Req && mem_cnt >= lat) begin
         bus.IMem_Valid = 1'b1;
         bus.IMem_Data  = 16'(bus.IMem_Addr) + 16'h100;
      end else begin
         bus.IMem_Valid = spur && !bus.IMem_Req;
         bus.IMem_Data  = IW'($urandom);
      end
   endtask

   task automatic tick();
      bit pr, pv;
      pr = bus.IMem_Req;
      pv = bus.IMem_Valid;
      @(posedge clk);
      model_step();
      if (pr && pv)  mem_cnt = 0;
      else if (pr)   mem_cnt = mem_cnt + 1;
      else           mem_cnt = 0;
      #1;
   endtask

   task automatic idle_cycle();
      drive(0, 0, '0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.IMem_Valid = 1'b0;
      bus.IMem_Data  = '0;
      drive(0, 0, '0, 0, 0, 0, 0);
      #1;
      tick();
      chk_en = 1'b1;
      idle_cycle();
      cmp("rst_req",    32'(bus.IMem_Req),  32'd0);
      cmp("rst_addr",   32'(bus.IMem_Addr), 32'd0);
      cmp("rst_if_v",   32'(if_valid),      32'd0);
      cmp("rst_if_pc",  32'(if_pc),         32'd0);

      // Combinational memory: first request, then one instruction per cycle.
      rst_n = 1'b1;
      idle_cycle();
      cmp("first_req",  32'(bus.IMem_Req),  32'd1);
      cmp("first_addr", 32'(bus.IMem_Addr), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         idle_cycle();
         cmp("seq_if_pc",  32'(if_pc),     32'(k - 2));
         cmp("seq_old_pc", 32'(old_pc),    32'(k - 1));
         cmp("seq_id_v",   32'(id_valid),  32'(k >= 3));
         cmp("seq_ex_v",   32'(ex_valid),  32'(k >= 4));
         cmp("seq_mem_v",  32'(mem_valid), 32'(k >= 5));
      end

      // Stall as the response for address 5 arrives.
      for (int i = 0; i < 20 && bus.IMem_Addr != PW'(5); i++) idle_cycle();
      cmp("reach_addr5", 32'(bus.IMem_Addr), 32'd5);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, '0, 0, 0, 0, 0);
         tick();
         cmp("held_req",  32'(bus.IMem_Req), 32'd0);
         cmp("held_ex_v", 32'(ex_valid),     32'd0);
         cmp("held_if_pc", 32'(if_pc),       32'd4);
      end
      idle_cycle();
      cmp("unstall_if_pc", 32'(if_pc),         32'd5);
      cmp("unstall_instr", 32'(if_instr),      32'h105);
      cmp("unstall_addr",  32'(bus.IMem_Addr), 32'd6);

      // Two-cycle-latency memory; redirect to 40 while request 7 is in flight.
      lat = 2;
      for (int i = 0; i < 20 && bus.IMem_Addr != PW'(7); i++) idle_cycle();
      cmp("reach_addr7", 32'(bus.IMem_Addr), 32'd7);
      idle_cycle();
      drive(0, 1, PW'(40), 0, 0, 0, 0);
      tick();
      cmp("drop_old_pc", 32'(old_pc),        32'd40);
      cmp("drop_addr",   32'(bus.IMem_Addr), 32'd7);
      cmp("drop_req",    32'(bus.IMem_Req),  32'd1);
      cmp("drop_if_v",   32'(if_valid),      32'd0);
      for (int i = 0; i < 10 && bus.IMem_Addr == PW'(7); i++) begin
         idle_cycle();
         cmp("drop_kill_if_v", 32'(if_valid), 32'd0);
         cmp("drop_instr",     32'(if_instr), 32'h106);
      end
      cmp("redir_addr", 32'(bus.IMem_Addr), 32'd40);

      // Redirect with REG/EX masks while the pipe is full.
      lat = 0;
      for (int i = 0; i < 20 && !(if_valid && id_valid && ex_valid && mem_valid); i++)
         idle_cycle();
      cmp("pipe_full", 32'(if_valid && id_valid && ex_valid && mem_valid), 32'd1);
      drive(0, 1, PW'(100), 1, 1, 0, 0);
      tick();
      cmp("mask_id_v",  32'(id_valid),  32'd0);
      cmp("mask_ex_v",  32'(ex_valid),  32'd0);
      cmp("mask_mem_v", 32'(mem_valid), 32'd1);
      cmp("mask_if_v",  32'(if_valid),  32'd0);

      // PC wrap at 8191.
      drive(0, 1, PW'(8191), 0, 0, 0, 0);
      tick();
      cmp("wrap_pre_pc", 32'(old_pc), 32'd8191);
      idle_cycle();
      cmp("wrap_old_pc", 32'(old_pc),   32'd0);
      cmp("wrap_if_pc",  32'(if_pc),    32'd8191);
      cmp("wrap_instr",  32'(if_instr), 32'h20FF);

      // Reset while discarding an in-flight response.
      lat = 3;
      drive(0, 1, PW'(200), 0, 0, 0, 0);
      tick();
      cmp("pre_rst_old_pc", 32'(old_pc), 32'd200);
      rst_n = 1'b0;
      idle_cycle();
      cmp("drst_req",    32'(bus.IMem_Req),  32'd0);
      cmp("drst_addr",   32'(bus.IMem_Addr), 32'd0);
      cmp("drst_old_pc", 32'(old_pc),        32'd0);
      cmp("drst_instr",  32'(if_instr),      32'd0);
      cmp("drst_valids", 32'({if_valid, id_valid, ex_valid, mem_valid}), 32'd0);
      rst_n = 1'b1;
      drive(0, 0, '0, 0, 0, 0, 1);
      tick();
      cmp("late_if_v",  32'(if_valid),      32'd0);
      cmp("late_instr", 32'(if_instr),      32'd0);
      cmp("late_req",   32'(bus.IMem_Req),  32'd1);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 49) == 0) lat = int'($urandom_range(0, 3));
         rst_n = ($urandom_range(0, 149) != 0);
         drive($urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0,
               ($urandom_range(0, 3) == 0) ? PW'($urandom_range(8188, 8191)) : PW'($urandom),
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0);
         tick();
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-side companion to the PC control unit: owns the program counter register, drives instruction-memory requests, and applies that unit's next-PC and flush masks to the front-end pipeline. Feeds `Old_PC` to the PC control unit and receives back `Next_PC`, a redirect strobe and `REG_Mask`/`EX_Mask`/`MEM_Mask`. Produces the IF/ID instruction latch and per-stage valid bits, which downstream pipeline registers use as write-enables and bubble markers.

## Interface
- `PC_WIDTH`, 13: program counter width.
- `INSTR_WIDTH`, 16: instruction width.
- `RESET_PC`, 13'd0: PC value after reset.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `Reset_n`  in  1  reset, synchronous and active-low.
- `Stall`  in  1  hazard stall: hold the PC and IF/ID latch, and insert a bubble into EX.
- `Redirect`  in  1  PC control unit taken jump or branch; load `Next_PC`.
- `Next_PC`  in  PC_WIDTH  redirect target.
- `REG_Mask`, `EX_Mask`, `MEM_Mask`  in  1 each  kill the instruction entering ID, EX or MEM respectively.
- `IMem_Req`  out  1  fetch request, held high until `IMem_Valid`.
- `IMem_Addr`  out  PC_WIDTH  fetch address, stable while `IMem_Req` is high.
- `IMem_Valid`  in  1  response strobe for the current request.
- `IMem_Data`  in  INSTR_WIDTH  instruction, valid with `IMem_Valid`.
- `Old_PC`  out  PC_WIDTH  current PC register, sent to the PC control unit.
- `IF_Instr`, `IF_PC`  out  INSTR_WIDTH, PC_WIDTH  IF/ID latch contents.
- `IF_Valid`, `ID_Valid`, `EX_Valid`, `MEM_Valid`  out  1 each  stage valid bits.

## Operation
- FSM states:
  - IDLE: entered only from reset.
  - REQ: request outstanding.
  - HELD: response parked in the skid register during a stall.
  - DROP: an in-flight response must be discarded.
- IDLE: `IMem_Req`=0. Moves to REQ on the next cycle with `IMem_Addr`=PC.
- REQ: `IMem_Req`=1. The memory may assert `IMem_Valid` in any cycle of REQ, including the first.
  - `IMem_Valid` and no `Stall`: IF_Instr←IMem_Data, IF_PC←IMem_Addr, IF_Valid←1, PC←PC+1 (mod 2^PC_WIDTH), IMem_Addr←PC+1. Stay in REQ.
  - `IMem_Valid` and `Stall`: skid←IMem_Data. Go to HELD with `IMem_Req`=0. PC and IF latch hold.
  - No response yet: IF_Valid holds while `Stall` is high, otherwise it clears (bubble).
- HELD: when `Stall` drops, skid moves to the IF latch, IF_Valid←1, PC←PC+1, IMem_Addr←PC+1, and the FSM returns to REQ.
- `Redirect` has priority over `Stall` in every state:
  - PC←Next_PC, IF_Valid←0, skid is discarded.
  - From REQ with no `IMem_Valid` this cycle: go to DROP. `IMem_Addr` keeps the old address and `IMem_Req` stays 1.
  - From REQ with `IMem_Valid` this cycle, or from HELD: the data is discarded, IMem_Addr←Next_PC, and the FSM goes to REQ.
- DROP: on `IMem_Valid`, the data is discarded, IMem_Addr←PC, and the FSM goes to REQ. A new `Redirect` while in DROP updates the PC only.
- Stage valid bits:
  - Normal (no stall, or `Redirect` asserted): ID_Valid←IF_Valid&~REG_Mask, EX_Valid←ID_Valid&~EX_Mask, MEM_Valid←EX_Valid&~MEM_Mask.
  - Stall without `Redirect`: ID_Valid holds, EX_Valid←0, MEM_Valid←EX_Valid&~MEM_Mask.
- `Old_PC` always equals the PC register.

## Timing
- Reset (with `Reset_n`=0 at the edge):
  - PC=IMem_Addr=RESET_PC.
  - IMem_Req=0.
  - IF_Instr=0, IF_PC=0.
  - All valid bits 0, skid empty, state IDLE.
  - Reset overrides every other input, including mid-request and in DROP. A response arriving after reset is ignored because state is IDLE.
- First `IMem_Req`: one cycle after reset releases.
- Throughput: one instruction per cycle when the memory responds combinationally.
- Latency: IF_Valid rises one edge after `IMem_Valid`.
- Redirect: redirect seen at edge n gives `Old_PC`=Next_PC after edge n. The target request is issued the same cycle if nothing is outstanding, otherwise after the dropped response.
- PC wraps from 2^PC_WIDTH−1 to 0 with no error.

## Test plan
- Reset, then combinational memory returning `IMem_Data`=PC+16'h100 -> IMem_Req=1 one cycle after reset release; IF_PC sequence 0,1,2,3; `Old_PC` leads IF_PC by 1; ID/EX/MEM_Valid rise on successive edges.
- `Stall` high for 3 cycles as `IMem_Valid` arrives for address 5 -> state HELD, IMem_Req=0, EX_Valid=0 for 3 cycles; after release IF_PC=5 and `IMem_Addr`=6.
- 2-cycle-latency memory; `Redirect` with `Next_PC`=13'd40 in the cycle after request 7 is issued -> `IMem_Addr` stays 7 until `IMem_Valid`, that data never reaches IF, next request has address 40.
- `Redirect` plus `REG_Mask`=`EX_Mask`=1 with all valid bits 1 -> next cycle ID_Valid=0, EX_Valid=0, MEM_Valid=1, IF_Valid=0.
- PC at 13'd8191, combinational memory -> next `Old_PC`=0, IF_PC=8191.
- `Reset_n` low while in DROP -> outputs at reset values, state IDLE; a late `IMem_Valid` does not change IF_Valid.
